// File: rtl/npc_pkg.sv
// Shared encodings and BTB entry layout for the next-PC / branch predictor slice.
package npc_pkg;

    localparam int unsigned CNT_W_MAX = 3;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_COND = 2'b01,
        KIND_JUMP = 2'b10,
        KIND_JREG = 2'b11
    } res_kind_e;

    typedef enum logic [2:0] {
        COND_BLTZ = 3'b000,
        COND_BGEZ = 3'b001,
        COND_BEQ  = 3'b100,
        COND_BNE  = 3'b101,
        COND_BLEZ = 3'b110,
        COND_BGTZ = 3'b111
    } res_cond_e;

    // Width-independent part of a BTB entry; tag and target live in separately sized arrays.
    typedef struct packed {
        logic                 valid;
        res_kind_e            kind;
        logic [CNT_W_MAX-1:0] cnt;
    } btb_meta_t;

    // Saturating up/down step of a direction counter bounded by [0, max].
    function automatic logic [CNT_W_MAX-1:0] sat_step(input logic [CNT_W_MAX-1:0] cnt,
                                                      input logic                 up,
                                                      input logic [CNT_W_MAX-1:0] max);
        logic [CNT_W_MAX-1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != max) res = CNT_W_MAX'(cnt + CNT_W_MAX'(1));
        end else begin
            if (cnt != '0) res = CNT_W_MAX'(cnt - CNT_W_MAX'(1));
        end
        return res;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped BTB: zero-latency lookup for the fetch PC, trained by EX-stage resolutions.
module npc_btb
    import npc_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CNT_W       = 2,
    parameter bit          BP_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-3:0] lk_word_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_en_i,
    input  logic [XLEN-3:0] upd_word_i,
    input  logic            upd_taken_i,
    input  res_kind_e       upd_kind_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - 2 - IDX_W;
    localparam logic [CNT_W_MAX-1:0] CNT_MAX  = CNT_W_MAX'((1 << CNT_W) - 1);
    localparam logic [CNT_W_MAX-1:0] CNT_WEAK = CNT_W_MAX'(1 << (CNT_W - 1));

    btb_meta_t         meta_q [BTB_ENTRIES];
    btb_meta_t         meta_d [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_d  [BTB_ENTRIES];
    logic [XLEN-1:0]   tgt_q  [BTB_ENTRIES];
    logic [XLEN-1:0]   tgt_d  [BTB_ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              lk_hit;
    logic              up_hit;

    assign lk_idx = lk_word_i[IDX_W-1:0];
    assign lk_tag = lk_word_i[XLEN-3:IDX_W];
    assign up_idx = upd_word_i[IDX_W-1:0];
    assign up_tag = upd_word_i[XLEN-3:IDX_W];

    // Lookup reads the registered array, so a same-cycle update is not visible yet.
    always_comb begin
        lk_hit        = meta_q[lk_idx].valid && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = 1'b0;
        pred_target_o = '0;
        if (BP_EN && lk_hit &&
            (meta_q[lk_idx].kind == KIND_JUMP || meta_q[lk_idx].kind == KIND_JREG ||
             meta_q[lk_idx].cnt[CNT_W-1])) begin
            pred_taken_o  = 1'b1;
            pred_target_o = tgt_q[lk_idx];
        end
    end

    // Training: hits step the counter and refresh the target, taken misses allocate weak-taken.
    always_comb begin
        meta_d = meta_q;
        tag_d  = tag_q;
        tgt_d  = tgt_q;
        up_hit = meta_q[up_idx].valid && (tag_q[up_idx] == up_tag);
        if (upd_en_i) begin
            if (up_hit) begin
                meta_d[up_idx].cnt  = sat_step(meta_q[up_idx].cnt, upd_taken_i, CNT_MAX);
                meta_d[up_idx].kind = upd_kind_i;
                tgt_d[up_idx]       = upd_target_i;
            end else if (upd_taken_i) begin
                meta_d[up_idx].valid = 1'b1;
                meta_d[up_idx].kind  = upd_kind_i;
                meta_d[up_idx].cnt   = CNT_WEAK;
                tag_d[up_idx]        = up_tag;
                tgt_d[up_idx]        = upd_target_i;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                meta_q[i] <= '{valid: 1'b0, kind: KIND_NONE, cnt: '0};
                tag_q[i]  <= '0;
                tgt_q[i]  <= '0;
            end
        end else begin
            meta_q <= meta_d;
            tag_q  <= tag_d;
            tgt_q  <= tgt_d;
        end
    end

endmodule

// File: rtl/npc_bpred.sv
// Fetch-stage next-PC generator: PC register, EX-stage branch resolution and redirect mux.
module npc_bpred
    import npc_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'hBFC0_0000),
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter int unsigned     CNT_W       = 2,
    parameter bit              BP_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            fetch_valid_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            res_valid_i,
    input  logic [XLEN-1:0] res_pc_i,
    input  logic [1:0]      res_kind_i,
    input  logic [2:0]      res_cond_i,
    input  logic [XLEN-1:0] res_rs_i,
    input  logic [XLEN-1:0] res_rt_i,
    input  logic [XLEN-1:0] res_imm_i,
    input  logic [25:0]     res_idx26_i,
    input  logic            res_pred_taken_i,
    input  logic [XLEN-1:0] res_pred_tgt_i,
    input  logic            exc_valid_i,
    input  logic [XLEN-1:0] exc_vec_i,
    output logic            flush_o,
    output logic            res_taken_o,
    output logic [31:0]     mispred_cnt_o
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic [31:0]     mispred_cnt_q, mispred_cnt_d;

    logic            res_active;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus8;
    logic [XLEN-1:0] correct_pc;
    res_kind_e       kind;

    assign kind       = res_kind_e'(res_kind_i);
    assign res_active = res_valid_i && (kind != KIND_NONE);
    assign pc_plus4   = res_pc_i + XLEN'(4);
    assign pc_plus8   = pc_plus4 + XLEN'(4);

    npc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .CNT_W       (CNT_W),
        .BP_EN       (BP_EN)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lk_word_i     (fetch_pc_q[XLEN-1:2]),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_en_i      (res_active),
        .upd_word_i    (res_pc_i[XLEN-1:2]),
        .upd_taken_i   (taken),
        .upd_kind_i    (kind),
        .upd_target_i  (target)
    );

    // Actual direction and target of the resolving instruction.
    always_comb begin
        taken  = 1'b0;
        target = '0;
        unique case (kind)
            KIND_COND: begin
                target = pc_plus4 + (res_imm_i << 2);
                case (res_cond_e'(res_cond_i))
                    COND_BLTZ: taken = res_rs_i[XLEN-1];
                    COND_BGEZ: taken = !res_rs_i[XLEN-1];
                    COND_BEQ:  taken = (res_rs_i == res_rt_i);
                    COND_BNE:  taken = (res_rs_i != res_rt_i);
                    COND_BLEZ: taken = res_rs_i[XLEN-1] || (res_rs_i == '0);
                    COND_BGTZ: taken = !res_rs_i[XLEN-1] && (res_rs_i != '0);
                    default:   taken = 1'b0;
                endcase
            end
            KIND_JUMP: begin
                taken  = 1'b1;
                target = {pc_plus4[XLEN-1:28], res_idx26_i, 2'b00};
            end
            KIND_JREG: begin
                taken  = 1'b1;
                target = res_rs_i;
            end
            default: begin
                taken  = 1'b0;
                target = '0;
            end
        endcase
    end

    assign res_taken_o = taken;
    assign flush_o     = res_active &&
                         ((taken != res_pred_taken_i) || (taken && (target != res_pred_tgt_i)));
    assign correct_pc  = taken ? target : pc_plus8;

    // Next-PC priority; a bubble cycle (fetch_valid low) holds the PC so the redirect target is fetched.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = 1'b1;
        mispred_cnt_d = mispred_cnt_q;
        if (exc_valid_i) begin
            fetch_pc_d    = exc_vec_i;
            fetch_valid_d = 1'b0;
        end else if (flush_o) begin
            fetch_pc_d    = correct_pc;
            fetch_valid_d = 1'b0;
        end else if (stall_i || !fetch_valid_q) begin
            fetch_pc_d    = fetch_pc_q;
        end else if (pred_taken_o) begin
            fetch_pc_d    = pred_target_o;
        end else begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
        end
        if (flush_o && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // Fetch PC, valid and mispredict counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            fetch_valid_q <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign fetch_pc_o    = fetch_pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred with a queue of expected fetch PC/valid states.
module tb_npc_bpred;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic [31:0] fetch_pc_o;
    logic        fetch_valid_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        res_valid_i;
    logic [31:0] res_pc_i;
    logic [1:0]  res_kind_i;
    logic [2:0]  res_cond_i;
    logic [31:0] res_rs_i;
    logic [31:0] res_rt_i;
    logic [31:0] res_imm_i;
    logic [25:0] res_idx26_i;
    logic        res_pred_taken_i;
    logic [31:0] res_pred_tgt_i;
    logic        exc_valid_i;
    logic [31:0] exc_vec_i;
    logic        flush_o;
    logic        res_taken_o;
    logic [31:0] mispred_cnt_o;

    npc_bpred dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_valid_o    (fetch_valid_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .res_valid_i      (res_valid_i),
        .res_pc_i         (res_pc_i),
        .res_kind_i       (res_kind_i),
        .res_cond_i       (res_cond_i),
        .res_rs_i         (res_rs_i),
        .res_rt_i         (res_rt_i),
        .res_imm_i        (res_imm_i),
        .res_idx26_i      (res_idx26_i),
        .res_pred_taken_i (res_pred_taken_i),
        .res_pred_tgt_i   (res_pred_tgt_i),
        .exc_valid_i      (exc_valid_i),
        .exc_vec_i        (exc_vec_i),
        .flush_o          (flush_o),
        .res_taken_o      (res_taken_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge state, advance one clock, then pop and compare.
    task automatic tick_exp(input logic [31:0] pc, input logic v);
        exp_t e;
        exp_q.push_back('{pc: pc, valid: v});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("fetch_pc", fetch_pc_o, e.pc);
        check_eq("fetch_valid", 32'(fetch_valid_o), 32'(e.valid));
    endtask

    task automatic drive_res(input logic [31:0] pc, input logic [1:0] kind, input logic [2:0] cond,
                             input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                             input logic [25:0] idx, input logic pt, input logic [31:0] ptgt);
        res_valid_i      = 1'b1;
        res_pc_i         = pc;
        res_kind_i       = kind;
        res_cond_i       = cond;
        res_rs_i         = rs;
        res_rt_i         = rt;
        res_imm_i        = imm;
        res_idx26_i      = idx;
        res_pred_taken_i = pt;
        res_pred_tgt_i   = ptgt;
        #1;
    endtask

    task automatic clear_res();
        res_valid_i      = 1'b0;
        res_kind_i       = 2'b00;
        res_pred_taken_i = 1'b0;
        res_pred_tgt_i   = '0;
    endtask

    task automatic redirect(input logic [31:0] vec);
        exc_valid_i = 1'b1;
        exc_vec_i   = vec;
        tick_exp(vec, 1'b0);
        exc_valid_i = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  cond;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        taken;
    } cond_vec_t;

    cond_vec_t cv[11];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; exc_valid_i = 1'b0; exc_vec_i = '0;
        res_pc_i = '0; res_cond_i = '0; res_rs_i = '0; res_rt_i = '0; res_imm_i = '0;
        res_idx26_i = '0;
        clear_res();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pc", fetch_pc_o, 32'hBFC0_0000);
        check_eq("rst_valid", 32'(fetch_valid_o), 32'd0);
        check_eq("rst_mis", mispred_cnt_o, 32'd0);
        check_eq("rst_pred", 32'(pred_taken_o), 32'd0);

        rst = 1'b0;
        tick_exp(32'hBFC0_0000, 1'b1);
        tick_exp(32'hBFC0_0004, 1'b1);
        tick_exp(32'hBFC0_0008, 1'b1);

        // beq taken, predicted not-taken: allocate and redirect to 0x114
        drive_res(32'h100, 2'b01, 3'b100, 32'd5, 32'd5, 32'd4, '0, 1'b0, 32'd0);
        check_eq("beq_taken", 32'(res_taken_o), 32'd1);
        check_eq("beq_flush", 32'(flush_o), 32'd1);
        tick_exp(32'h114, 1'b0);
        clear_res();
        exp_mis++;
        check_eq("mis_beq", mispred_cnt_o, 32'(exp_mis));
        tick_exp(32'h114, 1'b1);
        tick_exp(32'h118, 1'b1);

        // Refetch 0x100: weak-taken entry predicts 0x114
        redirect(32'h100);
        check_eq("refetch_pred", 32'(pred_taken_o), 32'd1);
        check_eq("refetch_tgt", pred_target_o, 32'h114);
        tick_exp(32'h100, 1'b1);
        tick_exp(32'h114, 1'b1);

        // Three more correctly predicted taken resolutions push the counter to saturation
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_res(32'h100, 2'b01, 3'b100, 32'd5, 32'd5, 32'd4, '0, 1'b1, 32'h114);
            check_eq("sat_noflush", 32'(flush_o), 32'd0);
            tick_exp(32'h114, 1'b1);
        end
        clear_res();
        stall_i = 1'b0;

        // One not-taken: saturated 3 -> 2, still predicts taken
        drive_res(32'h100, 2'b01, 3'b100, 32'd5, 32'd6, 32'd4, '0, 1'b1, 32'h114);
        check_eq("nt_flush", 32'(flush_o), 32'd1);
        tick_exp(32'h108, 1'b0);
        clear_res();
        exp_mis++;
        redirect(32'h100);
        check_eq("sat_hold_pred", 32'(pred_taken_o), 32'd1);

        // Second not-taken while fetching the same index: lookup still sees the old entry
        drive_res(32'h100, 2'b01, 3'b100, 32'd5, 32'd6, 32'd4, '0, 1'b1, 32'h114);
        check_eq("old_entry_pred", 32'(pred_taken_o), 32'd1);
        check_eq("nt2_flush", 32'(flush_o), 32'd1);
        tick_exp(32'h108, 1'b0);
        clear_res();
        exp_mis++;
        redirect(32'h100);
        check_eq("weak_nt_pred", 32'(pred_taken_o), 32'd0);
        check_eq("weak_nt_tgt", pred_target_o, 32'd0);
        check_eq("mis_3", mispred_cnt_o, 32'(exp_mis));

        // bgtz with negative rs, predicted taken: falls through past the delay slot
        drive_res(32'h200, 2'b01, 3'b111, 32'hFFFF_FFFF, 32'd0, 32'd4, '0, 1'b1, 32'h210);
        check_eq("bgtz_taken", 32'(res_taken_o), 32'd0);
        check_eq("bgtz_flush", 32'(flush_o), 32'd1);
        tick_exp(32'h208, 1'b0);
        clear_res();
        exp_mis++;
        check_eq("mis_bgtz", mispred_cnt_o, 32'(exp_mis));

        // jr to a different target than predicted
        drive_res(32'h300, 2'b11, 3'b000, 32'h8000_0040, 32'd0, 32'd0, '0, 1'b1, 32'h8000_0030);
        check_eq("jr_flush", 32'(flush_o), 32'd1);
        tick_exp(32'h8000_0040, 1'b0);
        clear_res();
        exp_mis++;

        // j whose pc+4 crosses a 256MB region boundary
        drive_res(32'h0FFF_FFFC, 2'b10, 3'b000, 32'd0, 32'd0, 32'd0, 26'h40, 1'b0, 32'd0);
        check_eq("j_taken", 32'(res_taken_o), 32'd1);
        tick_exp(32'h1000_0100, 1'b0);
        clear_res();
        exp_mis++;
        check_eq("mis_j", mispred_cnt_o, 32'(exp_mis));

        // Condition table at 0x500 (imm 0 -> target 0x504), predictions match so no flush
        cv[0]  = '{3'b000, 32'd0,          32'd0, 1'b0};
        cv[1]  = '{3'b000, 32'hFFFF_FFFF,  32'd0, 1'b1};
        cv[2]  = '{3'b001, 32'd0,          32'd0, 1'b1};
        cv[3]  = '{3'b001, 32'h8000_0000,  32'd0, 1'b0};
        cv[4]  = '{3'b110, 32'd0,          32'd0, 1'b1};
        cv[5]  = '{3'b110, 32'd1,          32'd0, 1'b0};
        cv[6]  = '{3'b111, 32'd1,          32'd0, 1'b1};
        cv[7]  = '{3'b111, 32'd0,          32'd0, 1'b0};
        cv[8]  = '{3'b100, 32'd7,          32'd7, 1'b1};
        cv[9]  = '{3'b101, 32'd7,          32'd7, 1'b0};
        cv[10] = '{3'b101, 32'd7,          32'd8, 1'b1};
        stall_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive_res(32'h500, 2'b01, cv[i].cond, cv[i].rs, cv[i].rt, 32'd0, '0,
                      cv[i].taken, cv[i].taken ? 32'h504 : 32'd0);
            check_eq($sformatf("cond%0d_taken", i), 32'(res_taken_o), 32'(cv[i].taken));
            check_eq($sformatf("cond%0d_flush", i), 32'(flush_o), 32'd0);
            tick_exp(32'h1000_0100, 1'b1);
        end
        clear_res();

        // exception, mispredict and stall together: exception vector wins
        exc_valid_i = 1'b1;
        exc_vec_i   = 32'h500;
        drive_res(32'h604, 2'b01, 3'b100, 32'd1, 32'd1, 32'd0, '0, 1'b0, 32'd0);
        check_eq("exc_flush", 32'(flush_o), 32'd1);
        tick_exp(32'h500, 1'b0);
        exc_valid_i = 1'b0;
        clear_res();
        exp_mis++;
        check_eq("mis_exc", mispred_cnt_o, 32'(exp_mis));
        check_eq("trained_pred", 32'(pred_taken_o), 32'd1);
        check_eq("trained_tgt", pred_target_o, 32'h504);

        // Reset asserted asynchronously mid-stall clears everything
        #3;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_pc", fetch_pc_o, 32'hBFC0_0000);
        check_eq("mid_rst_valid", 32'(fetch_valid_o), 32'd0);
        check_eq("mid_rst_mis", mispred_cnt_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_i = 1'b0;
        redirect(32'h500);
        check_eq("rst_btb_cleared", 32'(pred_taken_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
